ioctl_loader: RTL and testbench



---
 rtl/ioctl_loader.sv | 178 +++++++++++++++++
 tb/tb_ioctl_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_loader.sv
// ioctl_loader: moves an ioctl download byte stream into SDRAM, one byte
// per memory slot, through a small FIFO. One index can be redirected to the
// CMOS RAM write port; that path exists only when IOCTL_LOADER_CMOS_EN is
// defined. Without it the CMOS port is tied to zero and bytes for that
// index are dropped without being counted.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no download running; the FIFO may still finish draining
// S_LOAD  | download window open; accepted bytes are queued and counted
// S_DRAIN | window closed; waiting for the FIFO to empty on a slot
// S_DONE  | one-cycle completion pulse
module ioctl_loader #(
  parameter int                ADDR_W     = 25,
  parameter int                DEPTH      = 4,
  parameter logic [ADDR_W-1:0] BASE_MAIN  = 25'h080000,
  parameter logic [ADDR_W-1:0] BASE_ALT   = 25'h028000,
  parameter logic [7:0]        CMOS_INDEX = 8'hFF
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              mem_sync,
  output logic              ldr_we,
  output logic [ADDR_W-1:0] ldr_addr,
  output logic [7:0]        ldr_data,
  output logic              cmos_we,
  output logic [6:0]        cmos_addr,
  output logic [7:0]        cmos_data,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W-1:0] byte_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              dl_q;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PW:0]       cnt_q;
  logic [ADDR_W-1:0] mem_addr_q [DEPTH];
  logic [7:0]        mem_data_q [DEPTH];
  logic              ldr_we_q;
  logic [ADDR_W-1:0] ldr_addr_q;
  logic [7:0]        ldr_data_q;
  logic              overflow_q, overflow_d;
  logic [ADDR_W-1:0] byte_count_q, byte_count_d;

  logic              acc, empty, full, pop, push, drop, rise, fall;
  logic [ADDR_W-1:0] push_addr;
  logic [ADDR_W-1:0] count_base;

  // Accept/push/pop decisions; a pop frees a slot for a push in the same cycle.
  always_comb begin
    acc       = ioctl_wr && ioctl_download && (ioctl_index != CMOS_INDEX);
    empty     = (cnt_q == '0);
    full      = (cnt_q == FULL_CNT);
    pop       = mem_sync && !empty;
    push      = acc && (!full || pop);
    drop      = acc && full && !pop;
    rise      = ioctl_download && !dl_q;
    fall      = !ioctl_download && dl_q;
    push_addr = ioctl_addr + ((ioctl_index == 8'h00) ? BASE_MAIN : BASE_ALT);
  end

  // Counter and sticky overflow restart on each new download window.
  always_comb begin
    count_base   = rise ? '0 : byte_count_q;
    byte_count_d = push ? count_base + 1'b1 : count_base;
    overflow_d   = (rise ? 1'b0 : overflow_q) | drop;
  end

  // Next-state logic; a fresh download during drain or done reopens LOAD.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (rise) state_d = S_LOAD;
      S_LOAD:  if (fall) state_d = S_DRAIN;
      S_DRAIN: begin
        if (rise)                   state_d = S_LOAD;
        else if (mem_sync && empty) state_d = S_DONE;
      end
      S_DONE:  state_d = rise ? S_LOAD : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, edge detector, counters and FIFO pointers.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      dl_q         <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      overflow_q   <= 1'b0;
      byte_count_q <= '0;
    end else begin
      state_q      <= state_d;
      dl_q         <= ioctl_download;
      overflow_q   <= overflow_d;
      byte_count_q <= byte_count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

  // FIFO storage; validity is tracked by the pointers, so no reset needed.
  always_ff @(posedge clk_sys) begin
    if (push) begin
      mem_addr_q[wr_ptr_q] <= push_addr;
      mem_data_q[wr_ptr_q] <= ioctl_dout;
    end
  end

  // SDRAM request only changes on a slot marker and then holds for the slot.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      ldr_we_q   <= 1'b0;
      ldr_addr_q <= '0;
      ldr_data_q <= '0;
    end else if (mem_sync) begin
      ldr_we_q <= !empty;
      if (!empty) begin
        ldr_addr_q <= mem_addr_q[rd_ptr_q];
        ldr_data_q <= mem_data_q[rd_ptr_q];
      end
    end
  end

`ifdef IOCTL_LOADER_CMOS_EN
  logic       cmos_we_q;
  logic [6:0] cmos_addr_q;
  logic [7:0] cmos_data_q;

  // CMOS bytes bypass the FIFO and are written one cycle after the strobe.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cmos_we_q   <= 1'b0;
      cmos_addr_q <= '0;
      cmos_data_q <= '0;
    end else begin
      cmos_we_q <= ioctl_wr && ioctl_download && (ioctl_index == CMOS_INDEX);
      if (ioctl_wr && ioctl_download && (ioctl_index == CMOS_INDEX)) begin
        cmos_addr_q <= ioctl_addr[6:0];
        cmos_data_q <= ioctl_dout;
      end
    end
  end

  assign cmos_we   = cmos_we_q;
  assign cmos_addr = cmos_addr_q;
  assign cmos_data = cmos_data_q;
`else
  assign cmos_we   = 1'b0;
  assign cmos_addr = '0;
  assign cmos_data = '0;
`endif

  assign ldr_we     = ldr_we_q;
  assign ldr_addr   = ldr_addr_q;
  assign ldr_data   = ldr_data_q;
  assign busy       = (state_q == S_LOAD) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
  assign overflow   = overflow_q;
  assign byte_count = byte_count_q;

endmodule

// File: tb/tb_ioctl_loader.sv
// Directed bench for ioctl_loader with default parameters.
module tb_ioctl_loader;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        mem_sync;
  logic        ldr_we;
  logic [24:0] ldr_addr;
  logic [7:0]  ldr_data;
  logic        cmos_we;
  logic [6:0]  cmos_addr;
  logic [7:0]  cmos_data;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [24:0] byte_count;

  int n_chk = 0;
  int n_err = 0;

  ioctl_loader dut (
    .clk_sys        (clk_sys),
    .rst_n          (rst_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .mem_sync       (mem_sync),
    .ldr_we         (ldr_we),
    .ldr_addr       (ldr_addr),
    .ldr_data       (ldr_data),
    .cmos_we        (cmos_we),
    .cmos_addr      (cmos_addr),
    .cmos_data      (cmos_data),
    .busy           (busy),
    .done           (done),
    .overflow       (overflow),
    .byte_count     (byte_count)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic slot();
    mem_sync = 1'b1;
    step();
    mem_sync = 1'b0;
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    step();
    ioctl_wr   = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index    = 8'h00;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    mem_sync       = 1'b0;
    repeat (2) step();

    // reset state
    chk("rst_ldr_we", 32'(ldr_we), 32'h0);
    chk("rst_ldr_addr", 32'(ldr_addr), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_bc", 32'(byte_count), 32'h0);
    chk("rst_cmos", 32'({cmos_we, cmos_addr, cmos_data}), 32'h0);
    rst_n = 1'b1;
    step();

    // two bytes on index 0, slots every 8 cycles
    ioctl_download = 1'b1;
    ioctl_index    = 8'h00;
    step();
    chk("t1_busy", 32'(busy), 32'h1);
    wr_byte(25'h0000, 8'hA5);
    wr_byte(25'h0001, 8'h5A);
    chk("t1_bc", 32'(byte_count), 32'd2);
    chk("t1_no_we", 32'(ldr_we), 32'h0);
    ioctl_download = 1'b0;
    step();
    chk("t1_drain_busy", 32'(busy), 32'h1);
    slot();
    chk("t1_we0", 32'(ldr_we), 32'h1);
    chk("t1_addr0", 32'(ldr_addr), 32'h080000);
    chk("t1_data0", 32'(ldr_data), 32'hA5);
    repeat (7) step();
    chk("t1_we_hold", 32'(ldr_we), 32'h1);
    slot();
    chk("t1_addr1", 32'(ldr_addr), 32'h080001);
    chk("t1_data1", 32'(ldr_data), 32'h5A);
    repeat (7) step();
    chk("t1_pre_done", 32'(done), 32'h0);
    slot();
    chk("t1_we_off", 32'(ldr_we), 32'h0);
    chk("t1_addr_hold", 32'(ldr_addr), 32'h080001);
    chk("t1_done", 32'(done), 32'h1);
    step();
    chk("t1_done_pulse", 32'(done), 32'h0);
    chk("t1_idle_busy", 32'(busy), 32'h0);

    // index 1, six writes into a 4-deep FIFO with no slots
    ioctl_download = 1'b1;
    ioctl_index    = 8'h01;
    step();
    for (int i = 0; i < 6; i++) wr_byte(25'(i), 8'(8'h10 + i));
    chk("t2_bc", 32'(byte_count), 32'd4);
    chk("t2_ovf", 32'(overflow), 32'h1);
    chk("t2_no_we", 32'(ldr_we), 32'h0);
    slot();
    chk("t2_addr0", 32'(ldr_addr), 32'h028000);
    chk("t2_data0", 32'(ldr_data), 32'h10);
    ioctl_download = 1'b0;
    step();
    for (int i = 1; i < 4; i++) begin
      slot();
      chk("t2_drain_we", 32'(ldr_we), 32'h1);
      chk("t2_drain_addr", 32'(ldr_addr), 32'h028000 + 32'(i));
      chk("t2_drain_data", 32'(ldr_data), 32'h10 + 32'(i));
    end
    slot();
    chk("t2_done", 32'(done), 32'h1);
    chk("t2_we_off", 32'(ldr_we), 32'h0);
    step();

    // full FIFO, push and slot in the same cycle
    ioctl_download = 1'b1;
    step();
    chk("t3_bc_clr", 32'(byte_count), 32'h0);
    chk("t3_ovf_clr", 32'(overflow), 32'h0);
    for (int i = 0; i < 4; i++) wr_byte(25'h100 + 25'(i), 8'(8'h20 + i));
    chk("t3_bc4", 32'(byte_count), 32'd4);
    mem_sync = 1'b1;
    wr_byte(25'h104, 8'h24);
    mem_sync = 1'b0;
    chk("t3_same_ovf", 32'(overflow), 32'h0);
    chk("t3_same_bc", 32'(byte_count), 32'd5);
    chk("t3_same_addr", 32'(ldr_addr), 32'h028100);
    chk("t3_same_data", 32'(ldr_data), 32'h20);
    wr_byte(25'h105, 8'h25);
    chk("t3_full_ovf", 32'(overflow), 32'h1);
    chk("t3_full_bc", 32'(byte_count), 32'd5);
    ioctl_download = 1'b0;
    step();
    for (int i = 1; i < 5; i++) begin
      slot();
      chk("t3_drain_addr", 32'(ldr_addr), 32'h028100 + 32'(i));
      chk("t3_drain_data", 32'(ldr_data), 32'h20 + 32'(i));
    end
    slot();
    chk("t3_done", 32'(done), 32'h1);
    step();

    // strobe outside the download window, then CMOS index
    ioctl_index = 8'h00;
    wr_byte(25'h0, 8'h99);
    chk("t4_ign_bc", 32'(byte_count), 32'd5);
    slot();
    chk("t4_ign_we", 32'(ldr_we), 32'h0);
    ioctl_download = 1'b1;
    ioctl_index    = 8'hFF;
    step();
    wr_byte(25'h0012, 8'h3C);
`ifdef IOCTL_LOADER_CMOS_EN
    chk("t4_cmos_we", 32'(cmos_we), 32'h1);
    chk("t4_cmos_addr", 32'(cmos_addr), 32'h12);
    chk("t4_cmos_data", 32'(cmos_data), 32'h3C);
    step();
    chk("t4_cmos_we_off", 32'(cmos_we), 32'h0);
`else
    chk("t4_cmos_off", 32'({cmos_we, cmos_addr, cmos_data}), 32'h0);
    step();
`endif
    chk("t4_cmos_bc", 32'(byte_count), 32'h0);
    slot();
    chk("t4_cmos_ldr", 32'(ldr_we), 32'h0);
    ioctl_download = 1'b0;
    step();
    slot();
    chk("t4_done", 32'(done), 32'h1);
    step();

    // reset mid-download with two entries queued
    ioctl_download = 1'b1;
    ioctl_index    = 8'h00;
    step();
    wr_byte(25'h0007, 8'h77);
    wr_byte(25'h0008, 8'h88);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", 32'(busy), 32'h0);
    chk("t5_rst_bc", 32'(byte_count), 32'h0);
    chk("t5_rst_addr", 32'(ldr_addr), 32'h0);
    chk("t5_rst_data", 32'(ldr_data), 32'h0);
    repeat (3) @(posedge clk_sys);
    #1;
    rst_n = 1'b1;
    step();
    chk("t5_rel_busy", 32'(busy), 32'h1);
    slot();
    chk("t5_rel_we", 32'(ldr_we), 32'h0);
    step();
    chk("t5_rel_we2", 32'(ldr_we), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
